// File: rtl/seq_pattern_detector.sv
// Purpose : serial sequence detector with a runtime pattern, don't-care mask and overlap mode.
// Latency : match is registered; it pulses the cycle after the final pattern bit is sampled.
// Backpr. : none; din is taken only when en=1, and cfg_load wins over en (din on that edge is dropped).
//
// Ports:
//   clk          rising-edge clock
//   r            asynchronous active-low reset
//   en, din      sample strobe and serial data bit
//   cfg_load     one-cycle strobe that loads cfg_pat / cfg_mask / cfg_overlap and flushes history
//   cfg_pat      pattern, bit 0 = most recently received bit
//   cfg_mask     1 = compare bit, 0 = don't care
//   cfg_overlap  1 = overlapping matches allowed, 0 = history is flushed after each match
//   match        registered one-cycle match pulse
//   armed        history holds PAT_W valid bits
//   match_cnt    saturating match count since reset or load
//
// Build option: define SEQDET_MATCH_CNT_EN to build the saturating match counter.
// Without it, match_cnt is tied to zero and no counter flops are built.

module seq_pattern_detector #(
    parameter int unsigned      PAT_W   = 6,
    parameter int unsigned      CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 6'b111011
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    output logic             match,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [PAT_W-1:0]   hist_q, hist_n;
    logic [FILL_W-1:0]  fill_q, fill_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [PAT_W-1:0]   mask_q, mask_n;
    logic               overlap_q, overlap_n;
    logic               match_q, match_n;

    logic [PAT_W-1:0]   hist_sh;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;

    // State register
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q   <= ST_FILL;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= RST_PAT;
            mask_q    <= '1;
            overlap_q <= 1'b1;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            hist_q    <= hist_n;
            fill_q    <= fill_n;
            pat_q     <= pat_n;
            mask_q    <= mask_n;
            overlap_q <= overlap_n;
            match_q   <= match_n;
        end
    end

    // Next-state logic
    always_comb begin
        hist_sh   = {hist_q[PAT_W-2:0], din};
        fill_inc  = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_W'(1));
        hit       = 1'b0;
        hist_n    = hist_q;
        fill_n    = fill_q;
        pat_n     = pat_q;
        mask_n    = mask_q;
        overlap_n = overlap_q;
        match_n   = 1'b0;

        if (cfg_load) begin
            pat_n     = cfg_pat;
            mask_n    = cfg_mask;
            overlap_n = cfg_overlap;
            hist_n    = '0;
            fill_n    = '0;
        end else if (en) begin
            // The compare uses the history including the bit arriving on this edge,
            // so the registered pulse lines up with the final sampled bit.
            hit     = (fill_inc == FILL_FULL) && (((hist_sh ^ pat_q) & mask_q) == '0);
            match_n = hit;
            if (hit && !overlap_q) begin
                hist_n = '0;
                fill_n = '0;
            end else begin
                hist_n = hist_sh;
                fill_n = fill_inc;
            end
        end

        // FILL/ARMED track the fill counter, so the next state follows fill_n.
        state_n = (fill_n == FILL_FULL) ? ST_ARMED : ST_FILL;
    end

    // Outputs
    always_comb begin
        armed = (state_q == ST_ARMED);
        match = match_q;
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cnt_q <= '0;
        end else if (cfg_load) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Purpose : directed bench for seq_pattern_detector (PAT_W=6; CNT_W=8 main instance, CNT_W=4 saturation instance).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : n/a.

module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       r;
    logic       en;
    logic       din;
    logic       cfg_load;
    logic [5:0] cfg_pat;
    logic [5:0] cfg_mask;
    logic       cfg_overlap;

    logic       match, armed;
    logic [7:0] match_cnt;
    logic       match2, armed2;
    logic [3:0] match_cnt2;

    int checks   = 0;
    int failures = 0;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(6), .CNT_W(8), .RST_PAT(6'b111011)) dut (
        .clk(clk), .r(r), .en(en), .din(din),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
        .match(match), .armed(armed), .match_cnt(match_cnt)
    );

    seq_pattern_detector #(.PAT_W(6), .CNT_W(4), .RST_PAT(6'b111011)) dut_c4 (
        .clk(clk), .r(r), .en(en), .din(din),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
        .match(match2), .armed(armed2), .match_cnt(match_cnt2)
    );

    // Expected counter value after a number of hits, honouring saturation and the build option.
    function automatic int cnt_exp(input int hits, input int maxv);
        if (!CNT_ON) return 0;
        return (hits > maxv) ? maxv : hits;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic d);
        @(negedge clk);
        cfg_load = 1'b0;
        en       = e;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    // Load with en=1/din=1 on the same edge: that bit must be discarded.
    task automatic load(input logic [5:0] pat, input logic [5:0] mask, input logic ov);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pat     = pat;
        cfg_mask    = mask;
        cfg_overlap = ov;
        en          = 1'b1;
        din         = 1'b1;
        @(posedge clk);
        #1;
        chk("load_match", 32'(match), 32'd0);
        chk("load_armed", 32'(armed), 32'd0);
        chk("load_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        cfg_load = 1'b0;
        en       = 1'b0;
    endtask

    // Send n bits MSB first; expm[i] is the expected match after sending bits[i].
    task automatic send(input string tag, input logic [31:0] bits, input int n, input logic [31:0] expm);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i]);
            chk($sformatf("%s_bit%0d", tag, n - i), 32'(match), 32'(expm[i]));
        end
    endtask

    initial begin
        r           = 1'b0;
        en          = 1'b0;
        din         = 1'b0;
        cfg_load    = 1'b0;
        cfg_pat     = 6'b0;
        cfg_mask    = 6'b0;
        cfg_overlap = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        r = 1'b1;

        // Reset pattern 111011
        send("t1a", 32'b11101, 5, 32'b0);
        chk("t1_armed_pre", 32'(armed), 32'd0);
        send("t1b", 32'b1, 1, 32'b1);
        chk("t1_armed", 32'(armed), 32'd1);
        chk("t1_cnt", 32'(match_cnt), 32'(cnt_exp(1, 255)));
        step(1'b0, 1'b0);
        chk("t1_pulse_end", 32'(match), 32'd0);
        chk("t1_armed_hold", 32'(armed), 32'd1);

        // Overlap on: 110110110 matches after bits 6 and 9
        load(6'b110110, 6'b111111, 1'b1);
        send("t2_ov1", 32'b110110110, 9, 32'b000001001);
        chk("t2_ov1_cnt", 32'(match_cnt), 32'(cnt_exp(2, 255)));
        // Overlap off: history flushed after bit 6, so bit 9 cannot match
        load(6'b110110, 6'b111111, 1'b0);
        send("t2_ov0", 32'b110110110, 9, 32'b000001000);
        chk("t2_ov0_cnt", 32'(match_cnt), 32'(cnt_exp(1, 255)));
        chk("t2_ov0_armed", 32'(armed), 32'd0);

        // en gaps between bits 3 and 4
        load(6'b111011, 6'b111111, 1'b1);
        send("t3a", 32'b111, 3, 32'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            chk($sformatf("t3_gap%0d", k), 32'(match), 32'd0);
        end
        send("t3b", 32'b011, 3, 32'b001);
        chk("t3_cnt", 32'(match_cnt), 32'(cnt_exp(1, 255)));

        // Mask 111100: only bits 5..2 (oldest four) are compared against 1101
        load(6'b110100, 6'b111100, 1'b1);
        send("t4_exact", 32'b110100, 6, 32'b000001);
        load(6'b110100, 6'b111100, 1'b1);
        send("t4_dc", 32'b110111, 6, 32'b000001);
        load(6'b110100, 6'b111100, 1'b1);
        send("t4_miss", 32'b111100, 6, 32'b000000);
        chk("t4_miss_armed", 32'(armed), 32'd1);
        chk("t4_miss_cnt", 32'(match_cnt), 32'd0);

        // Reset mid-stream
        load(6'b111011, 6'b111111, 1'b1);
        send("t5a", 32'b111011, 6, 32'b000001);
        send("t5b", 32'b1110, 4, 32'b0);
        chk("t5_armed_pre", 32'(armed), 32'd1);
        @(negedge clk);
        r = 1'b0;
        #1;
        chk("t5_async_armed", 32'(armed), 32'd0);
        chk("t5_async_cnt", 32'(match_cnt), 32'd0);
        en  = 1'b1;
        din = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        r = 1'b1;
        send("t5c", 32'b11, 2, 32'b00);
        chk("t5_armed", 32'(armed), 32'd0);
        chk("t5_cnt", 32'(match_cnt), 32'd0);

        // Mask all-zero: every enabled sample once full is a hit; 4-bit counter saturates at 15
        load(6'b000000, 6'b000000, 1'b1);
        for (int k = 1; k <= 23; k++) begin
            int hits;
            hits = (k >= 6) ? (k - 5) : 0;
            step(1'b1, k[0]);
            chk($sformatf("t6_m%0d", k), 32'(match), (k >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("t6_m2_%0d", k), 32'(match2), (k >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("t6_c4_%0d", k), 32'(match_cnt2), 32'(cnt_exp(hits, 15)));
            chk($sformatf("t6_c8_%0d", k), 32'(match_cnt), 32'(cnt_exp(hits, 255)));
        end
        chk("t6_armed2", 32'(armed2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
